// File: rtl/secp256k1_jb_to_affine_if.sv
// Valid/ready stream bundle used for the modular-multiplier request and response paths.
// The source side drives payload and valid; the sink side drives ready.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8
);
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [DAT_BYTS*8-1:0] dat;
    logic [CTL_BITS-1:0]   ctl;
    logic [MOD_BITS-1:0]   mod;

    modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/secp256k1_jb_to_affine.sv
// Jacobian (x, y, z) to affine conversion over the secp256k1 field using an external
// modular multiplier; z^-1 is formed by left-to-right square-and-multiply of z^EXP.
package secp256k1_pkg;
    localparam logic [255:0] p_eq =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
        logic [255:0] z;
    } jb_point_t;
endpackage

module secp256k1_jb_to_affine #(
    parameter logic [255:0] P        = secp256k1_pkg::p_eq,
    parameter logic [255:0] EXP      = P - 256'd2,
    parameter int           CTL_BITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  secp256k1_pkg::jb_point_t  i_p,
    input  logic                      i_val,
    output logic                      o_rdy,
    output logic [255:0]              o_x,
    output logic [255:0]              o_y,
    output logic                      o_val,
    input  logic                      i_rdy,
    output logic                      o_err,
    if_axi_stream.source              o_mult_if,
    if_axi_stream.sink                i_mult_if
);

    function automatic int unsigned msb_index(input logic [255:0] v);
        int unsigned m;
        m = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

    localparam int unsigned EXP_MSB   = msb_index(EXP);
    localparam logic [7:0]  IDX_START = 8'(EXP_MSB - 1);

    typedef enum logic [2:0] {
        IDLE, INV_SQ, INV_MUL, ZINV2, ZINV3, MULX, MULY, OUT
    } state_t;

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         live_q;
    logic         err_q, err_d;
    logic [7:0]   idx_q, idx_d;
    logic [255:0] acc_q, acc_d;
    logic [255:0] zinv2_q, zinv2_d;
    logic [255:0] x_q, x_d;
    logic [255:0] y_q, y_d;
    logic [255:0] z_q, z_d;
    logic [255:0] op_a, op_b;
    logic         accept;
    logic         compute;
    logic         unused_rsp;

    assign compute = (state_q != IDLE) && (state_q != OUT);
    assign o_rdy   = live_q && (state_q == IDLE);
    assign accept  = i_val && o_rdy;
    assign o_val   = (state_q == OUT);
    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_err   = err_q;

    assign o_mult_if.val = compute && !busy_q;
    assign o_mult_if.dat = {op_b, op_a};
    assign o_mult_if.ctl = CTL_BITS'(state_q);
    assign o_mult_if.sop = 1'b1;
    assign o_mult_if.eop = 1'b1;
    assign o_mult_if.mod = '0;
    assign o_mult_if.err = 1'b0;
    assign i_mult_if.rdy = busy_q;
    assign unused_rsp    = ^{i_mult_if.sop, i_mult_if.eop, i_mult_if.mod};

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        err_d   = err_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        zinv2_d = zinv2_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        op_a    = acc_q;
        op_b    = acc_q;

        // acc holds the running power during inversion, then z^-1, then z^-3
        case (state_q)
            INV_MUL: op_b = z_q;
            ZINV3:   op_a = zinv2_q;
            MULX:    begin op_a = x_q; op_b = zinv2_q; end
            MULY:    op_a = y_q;
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_p.z == '0) begin
                        x_d     = '0;
                        y_d     = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end else if (i_p.z == 256'd1) begin
                        x_d     = i_p.x;
                        y_d     = i_p.y;
                        err_d   = 1'b0;
                        state_d = OUT;
                    end else begin
                        x_d     = i_p.x;
                        y_d     = i_p.y;
                        z_d     = i_p.z;
                        acc_d   = i_p.z;
                        idx_d   = IDX_START;
                        state_d = INV_SQ;
                    end
                end
            end
            OUT: begin
                if (i_rdy) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                if (!busy_q) begin
                    if (o_mult_if.rdy) busy_d = 1'b1;
                end else if (i_mult_if.val) begin
                    busy_d = 1'b0;
                    if (i_mult_if.err || (i_mult_if.ctl != CTL_BITS'(state_q))) err_d = 1'b1;
                    case (state_q)
                        INV_SQ: begin
                            acc_d = i_mult_if.dat;
                            if (EXP[idx_q])          state_d = INV_MUL;
                            else if (idx_q == 8'd0)  state_d = ZINV2;
                            else                     idx_d   = idx_q - 8'd1;
                        end
                        INV_MUL: begin
                            acc_d = i_mult_if.dat;
                            if (idx_q == 8'd0) begin
                                state_d = ZINV2;
                            end else begin
                                idx_d   = idx_q - 8'd1;
                                state_d = INV_SQ;
                            end
                        end
                        ZINV2:   begin zinv2_d = i_mult_if.dat; state_d = ZINV3; end
                        ZINV3:   begin acc_d   = i_mult_if.dat; state_d = MULX;  end
                        MULX:    begin x_d     = i_mult_if.dat; state_d = MULY;  end
                        MULY:    begin y_d     = i_mult_if.dat; state_d = OUT;   end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            live_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            zinv2_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            live_q  <= 1'b1;
            err_q   <= err_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            zinv2_q <= zinv2_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_secp256k1_jb_to_affine.sv
// Bench for secp256k1_jb_to_affine: a behavioural multiplier plus a field-arithmetic
// reference model; results are compared every cycle o_val is high.
module tb_secp256k1_jb_to_affine;
    import secp256k1_pkg::*;

    localparam logic [255:0] P   = p_eq;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic         err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    jb_point_t    i_p;
    logic         i_val;
    logic         o_rdy;
    logic [255:0] o_x, o_y;
    logic         o_val;
    logic         i_rdy;
    logic         o_err;

    int           checks = 0;
    int           errors = 0;
    int           hs_count = 0;
    int           viol = 0;
    int           inject_cd = 0;
    int           last_hs = 0;
    bit           rand_mreq = 1'b0;
    bit           rand_out = 1'b0;
    res_t         exp_q[$];
    logic [255:0] last_x, last_y;
    logic         last_err;

    if_axi_stream #(.DAT_BYTS(64), .CTL_BITS(8)) mreq ();
    if_axi_stream #(.DAT_BYTS(32), .CTL_BITS(8)) mresp ();

    secp256k1_jb_to_affine #(.P(P), .EXP(P - 256'd2), .CTL_BITS(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_p       (i_p),
        .i_val     (i_val),
        .o_rdy     (o_rdy),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_val     (o_val),
        .i_rdy     (i_rdy),
        .o_err     (o_err),
        .o_mult_if (mreq),
        .i_mult_if (mresp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        return 256'(t % {256'd0, P});
    endfunction

    function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e);
        logic [255:0] r;
        r = 256'd1;
        for (int i = 255; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, base);
        end
        return r;
    endfunction

    function automatic res_t model(input logic [255:0] x, input logic [255:0] y,
                                   input logic [255:0] z, input bit inj);
        res_t r;
        logic [255:0] zi, zi2;
        if (z == '0) begin
            r.x = '0; r.y = '0; r.err = 1'b1;
        end else if (z == 256'd1) begin
            r.x = x; r.y = y; r.err = 1'b0;
        end else begin
            zi  = powmod(z, P - 256'd2);
            zi2 = mulmod(zi, zi);
            r.x = mulmod(x, zi2);
            r.y = mulmod(y, mulmod(zi2, zi));
            r.err = inj;
        end
        return r;
    endfunction

    // Square-and-multiply cost: one squaring per bit below the MSB, one multiply per
    // further set bit, plus the four closing products.
    function automatic int expected_hs(input logic [255:0] z);
        logic [255:0] e;
        int msb, pop;
        if (z == '0 || z == 256'd1) return 0;
        e = P - 256'd2;
        msb = 0; pop = 0;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) begin msb = i; pop++; end
        end
        return msb + (pop - 1) + 4;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        r = r % P;
        if (r < 256'd2) r = 256'd2;
        return r;
    endfunction

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Behavioural multiplier: random request back-pressure and response latency.
    initial begin : mult_model
        bit           pending, taken, prev_wait;
        int           lat;
        logic [255:0] rdat;
        logic [7:0]   rctl, pctl;
        logic         rerr;
        logic [511:0] pdat;
        pending = 0; taken = 0; prev_wait = 0; lat = 0;
        rdat = '0; rctl = '0; rerr = 1'b0; pdat = '0; pctl = '0;
        mreq.rdy = 1'b0;
        mresp.val = 1'b0; mresp.dat = '0; mresp.ctl = '0; mresp.err = 1'b0;
        mresp.sop = 1'b1; mresp.eop = 1'b1; mresp.mod = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mreq.rdy = 1'b0; mresp.val = 1'b0; mresp.err = 1'b0;
                pending = 0; taken = 0; prev_wait = 0;
            end else begin
                if (taken) begin
                    mresp.val = 1'b0; mresp.err = 1'b0; pending = 0; taken = 0;
                end
                if (pending && !mresp.val) begin
                    if (lat == 0) begin
                        mresp.val = 1'b1; mresp.dat = rdat; mresp.ctl = rctl; mresp.err = rerr;
                    end else begin
                        lat--;
                    end
                end
                if (mresp.val && mresp.rdy) taken = 1;
                if (mresp.rdy && !pending) viol++;
                if (prev_wait && (!mreq.val || mreq.dat !== pdat || mreq.ctl !== pctl)) viol++;
                if (mreq.val && (mreq.sop !== 1'b1 || mreq.eop !== 1'b1 || mreq.mod !== '0 || mreq.err !== 1'b0)) viol++;
                mreq.rdy = rand_mreq ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (mreq.val && mreq.rdy) begin
                    if (pending) viol++;
                    rdat = mulmod(mreq.dat[255:0], mreq.dat[511:256]);
                    rctl = mreq.ctl;
                    rerr = 1'b0;
                    if (inject_cd == 1) begin rerr = 1'b1; inject_cd = 0; end
                    else if (inject_cd > 1) inject_cd--;
                    lat = $urandom_range(0, 3);
                    pending = 1;
                    hs_count++;
                end
                prev_wait = mreq.val && !mreq.rdy;
                pdat = mreq.dat;
                pctl = mreq.ctl;
            end
        end
    end

    initial begin : compare
        i_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_val) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_o_val: got o_val=1, required no pending result");
                    end else begin
                        check256("o_x", o_x, exp_q[0].x);
                        check256("o_y", o_y, exp_q[0].y);
                        check1("o_err", o_err, exp_q[0].err);
                    end
                end
                i_rdy = rand_out ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (o_val && i_rdy && exp_q.size() > 0) begin
                    last_x = o_x; last_y = o_y; last_err = o_err;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic submit(input string name, input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] z, input bit inj, output bit ok);
        int n;
        n = 0;
        ok = 0;
        @(negedge clk);
        while (!o_rdy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!o_rdy) begin
            checks++; errors++;
            $display("FAIL %s_accept: got o_rdy=0, required 1", name);
            return;
        end
        exp_q.push_back(model(x, y, z, inj));
        inject_cd = inj ? int'($urandom_range(1, 400)) : 0;
        i_p.x = x; i_p.y = y; i_p.z = z;
        i_val = 1'b1;
        @(negedge clk);
        i_val = 1'b0;
        ok = 1;
    endtask

    task automatic run_point(input string name, input logic [255:0] x, input logic [255:0] y,
                             input logic [255:0] z, input bit inj);
        int hs0;
        bit ok;
        hs0 = hs_count;
        submit(name, x, y, z, inj, ok);
        if (!ok) return;
        if (z == '0 || z == 256'd1) check1({name, "_bypass_latency"}, o_val, 1'b1);
        wait_done(name);
        last_hs = hs_count - hs0;
        check_int({name, "_handshakes"}, last_hs, expected_hs(z));
        check_int({name, "_protocol_violations"}, viol, 0);
    endtask

    initial begin : stimulus
        logic [255:0] z2, z3, z, x, y;
        bit ok;
        i_val = 1'b0;
        i_p   = '0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("reset_o_rdy", o_rdy, 1'b0);
        check1("reset_o_val", o_val, 1'b0);
        check1("reset_o_err", o_err, 1'b0);
        check256("reset_o_x", o_x, '0);
        check256("reset_o_y", o_y, '0);
        check1("reset_mult_val", mreq.val, 1'b0);
        check1("reset_rsp_rdy", mresp.rdy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("post_reset_o_rdy", o_rdy, 1'b1);

        run_point("G_bypass", GX, GY, 256'd1, 1'b0);
        check256("G_x_literal", last_x, GX);
        check256("G_y_literal", last_y, GY);

        z2 = mulmod(GY, 256'd2);
        run_point("2G", mulmod(G2X, mulmod(z2, z2)), mulmod(G2Y, mulmod(z2, mulmod(z2, z2))), z2, 1'b0);
        check256("2G_x_literal", last_x, G2X);
        check256("2G_y_literal", last_y, G2Y);
        check_int("2G_handshakes_literal", last_hs, 507);

        rand_mreq = 1'b1;
        rand_out  = 1'b1;
        z3 = rand256();
        run_point("3G_toggle", mulmod(G3X, mulmod(z3, z3)), mulmod(G3Y, mulmod(z3, mulmod(z3, z3))), z3, 1'b0);
        check256("3G_x_literal", last_x, G3X);
        check256("3G_y_literal", last_y, G3Y);

        run_point("z0_infinity", rand256(), rand256(), '0, 1'b0);
        check1("z0_err_literal", last_err, 1'b1);
        check256("z0_x_literal", last_x, '0);

        run_point("after_z0", rand256(), rand256(), rand256(), 1'b0);
        run_point("err_inject", rand256(), rand256(), rand256(), 1'b1);
        check1("err_inject_literal", last_err, 1'b1);
        run_point("after_err", rand256(), rand256(), rand256(), 1'b0);
        check1("after_err_literal", last_err, 1'b0);
        run_point("z_pm1", rand256(), rand256(), P - 256'd1, 1'b0);

        rand_mreq = 1'b0;
        rand_out  = 1'b0;
        x = rand256(); y = rand256(); z = rand256();
        submit("abort", x, y, z, 1'b0, ok);
        repeat (400) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        inject_cd = 0;
        #1;
        check1("midrun_reset_o_val", o_val, 1'b0);
        check1("midrun_reset_o_err", o_err, 1'b0);
        check256("midrun_reset_o_x", o_x, '0);
        check256("midrun_reset_o_y", o_y, '0);
        check1("midrun_reset_mult_val", mreq.val, 1'b0);
        check1("midrun_reset_rsp_rdy", mresp.rdy, 1'b0);
        check1("midrun_reset_o_rdy", o_rdy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("midrun_release_o_rdy", o_rdy, 1'b1);

        run_point("2G_fresh", mulmod(G2X, mulmod(z2, z2)), mulmod(G2Y, mulmod(z2, mulmod(z2, z2))), z2, 1'b0);
        check256("2G_fresh_x_literal", last_x, G2X);
        check256("2G_fresh_y_literal", last_y, G2Y);
        check_int("2G_fresh_handshakes_literal", last_hs, 507);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
